// File: rtl/gf163_pkg.sv
// Shared GF(2^163) constants, inverter FSM states and the Itoh-Tsujii step table.
package gf163_pkg;

  localparam int M = 163;
  localparam logic [M-1:0] POLY = 163'hC9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd8;

  // Squarings before each multiply of the chain 1,2,4,5,10,20,40,80,81,162.
  function automatic logic [6:0] sq_count(input logic [3:0] s);
    case (s)
      4'd0:    sq_count = 7'd1;
      4'd1:    sq_count = 7'd2;
      4'd2:    sq_count = 7'd1;
      4'd3:    sq_count = 7'd5;
      4'd4:    sq_count = 7'd10;
      4'd5:    sq_count = 7'd20;
      4'd6:    sq_count = 7'd40;
      4'd7:    sq_count = 7'd1;
      4'd8:    sq_count = 7'd81;
      default: sq_count = 7'd0;
    endcase
  endfunction

  // The +1 links of the chain multiply by the original operand instead of beta.
  function automatic logic use_areg(input logic [3:0] s);
    use_areg = (s == 4'd2) || (s == 4'd7);
  endfunction

endpackage

// File: rtl/gf163_sqr.sv
// Combinational GF(2^N) squarer: spread bits to even positions, then reduce mod x^N + P.
module gf163_sqr
  import gf163_pkg::*;
#(
  parameter int N = M,
  parameter logic [N-1:0] P = POLY
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  logic [2*N-2:0] s;

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[2*i] = a[i];
    end
    // Fold from the top down so a fold never sets a bit that was already visited.
    for (int i = 2*N-2; i >= N; i--) begin
      if (s[i]) begin
        s[i] = 1'b0;
        s[i-N +: N] = s[i-N +: N] ^ P;
      end
    end
    y = s[N-1:0];
  end

endmodule

// File: rtl/gf163_inv_ctrl.sv
// Sequential GF(2^163) Itoh-Tsujii inverter borrowing a shared multiplier via mul_req/mul_ack.
// Optional GF163_INV_ZERO_CHECK_EN: a==0 short-circuits to done after one cycle with err_zero set.
module gf163_inv_ctrl #(
  parameter int M = gf163_pkg::M,
  parameter logic [M-1:0] POLY = gf163_pkg::POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result,
  output logic         err_zero,
  output logic         mul_req,
  output logic [M-1:0] mul_op_a,
  output logic [M-1:0] mul_op_b,
  input  logic         mul_ack,
  input  logic [M-1:0] mul_res
);

  import gf163_pkg::*;

  state_t       state, state_d;
  logic [M-1:0] areg, beta, t, t_sq, result_q;
  logic [3:0]   step;
  logic [6:0]   sqcnt;
  logic         done_q;
  logic         zero_start;

  gf163_sqr #(.N(M), .P(POLY)) u_sqr (
    .a (t),
    .y (t_sq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = zero_start ? FIN : SQR;
      SQR:     if (sqcnt == 7'd1) state_d = MUL;
      MUL:     if (mul_ack) state_d = (step == LAST_STEP) ? FIN : SQR;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg     <= '0;
      beta     <= '0;
      t        <= '0;
      step     <= '0;
      sqcnt    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          areg  <= a;
          beta  <= a;
          t     <= a;
          step  <= 4'd0;
          sqcnt <= sq_count(4'd0);
        end
        SQR: begin
          t     <= t_sq;
          sqcnt <= sqcnt - 7'd1;
        end
        MUL: if (mul_ack) begin
          t     <= mul_res;
          beta  <= mul_res;
          step  <= step + 4'd1;
          sqcnt <= sq_count(step + 4'd1);
        end
        FIN: begin
          result_q <= t_sq;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GF163_INV_ZERO_CHECK_EN
  logic zero_flag, err_q;

  assign zero_start = (a == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      err_q     <= 1'b0;
    end else if (state == IDLE && start) begin
      zero_flag <= zero_start;
    end else if (state == FIN) begin
      err_q <= zero_flag;
    end
  end

  assign err_zero = err_q;
`else
  assign zero_start = 1'b0;
  assign err_zero   = 1'b0;
`endif

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign mul_req  = (state == MUL);
  assign mul_op_a = t;
  assign mul_op_b = use_areg(step) ? areg : beta;

endmodule
